// File: rtl/core_pkg.sv
// Shared types for the RV32 back-end pipeline: datapath widths, the data-memory
// handshake state encoding and the EX/MEM and MEM/WB register layouts.
package core_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } hs_state_e;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic            regwrite;
    logic            memread;
    logic            memwrite;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] store_data;
  } exmem_t;

  typedef struct packed {
    logic [RA_W-1:0] rd;
    logic            regwrite;
    logic [XLEN-1:0] data;
  } memwb_t;

  function automatic logic is_mem_op(input exmem_t s);
    return s.memread | s.memwrite;
  endfunction

endpackage

// File: rtl/dmem_handshake_fsm.sv
// Data-memory request/acknowledge sequencer. Request and stall are combinational
// so that a zero-wait memory completes without losing a cycle.
//
//   state | meaning
//   IDLE  | no request outstanding from a previous cycle
//   WAIT  | request issued, still waiting for dmem_ack
module dmem_handshake_fsm
  import core_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic mem_pending,
  input  logic dmem_ack,
  output logic dmem_req,
  output logic stall
);

  hs_state_e state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: if (mem_pending && !dmem_ack) state <= WAIT;
        WAIT: if (dmem_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // WAIT keeps the request up even if the pending flag were ever to glitch.
  assign dmem_req = mem_pending | (state == WAIT);
  assign stall    = mem_pending & ~dmem_ack;

endmodule

// File: rtl/exmem_memwb_pipe.sv
// EX/MEM and MEM/WB pipeline registers with the data-memory handshake. Supplies
// the forwarding tags/values and the register-file writeback port.
module exmem_memwb_pipe
  import core_pkg::*;
#(
  parameter int XLEN = core_pkg::XLEN,
  parameter int RA_W = core_pkg::RA_W
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            ex_regwrite,
  input  logic            ex_memread,
  input  logic            ex_memwrite,
  input  logic [XLEN-1:0] ex_alu_result,
  input  logic [XLEN-1:0] ex_store_data,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic [XLEN-1:0] dmem_rdata,
  input  logic            dmem_ack,
  output logic            stall,
  output logic [RA_W-1:0] exmem_rd,
  output logic            exmem_regwrite,
  output logic [XLEN-1:0] exmem_result,
  output logic [RA_W-1:0] memwb_rd,
  output logic            memwb_regwrite,
  output logic [XLEN-1:0] memwb_data
);

  exmem_t exmem_q;
  memwb_t memwb_q;
  logic   mem_pending;

  assign mem_pending = is_mem_op(exmem_q);

  dmem_handshake_fsm u_hs (
    .clk         (clk),
    .reset       (reset),
    .mem_pending (mem_pending),
    .dmem_ack    (dmem_ack),
    .dmem_req    (dmem_req),
    .stall       (stall)
  );

  // x0 is filtered on capture so neither forwarding tag ever names it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exmem_q <= '0;
    end else if (!stall) begin
      exmem_q.rd         <= ex_rd;
      exmem_q.regwrite   <= ex_valid & ex_regwrite & (ex_rd != '0);
      exmem_q.memread    <= ex_valid & ex_memread;
      exmem_q.memwrite   <= ex_valid & ex_memwrite;
      exmem_q.result     <= ex_alu_result;
      exmem_q.store_data <= ex_store_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      memwb_q <= '0;
    end else if (stall) begin
      memwb_q.regwrite <= 1'b0;
    end else if (exmem_q.memread) begin
      memwb_q.rd       <= exmem_q.rd;
      memwb_q.regwrite <= exmem_q.regwrite;
      memwb_q.data     <= dmem_rdata;
    end else if (exmem_q.memwrite) begin
      memwb_q.regwrite <= 1'b0;
    end else begin
      memwb_q.rd       <= exmem_q.rd;
      memwb_q.regwrite <= exmem_q.regwrite;
      memwb_q.data     <= exmem_q.result;
    end
  end

  assign dmem_we    = exmem_q.memwrite;
  assign dmem_addr  = exmem_q.result;
  assign dmem_wdata = exmem_q.store_data;

  assign exmem_rd       = exmem_q.rd;
  assign exmem_regwrite = exmem_q.regwrite;
  assign exmem_result   = exmem_q.result;

  assign memwb_rd       = memwb_q.rd;
  assign memwb_regwrite = memwb_q.regwrite;
  assign memwb_data     = memwb_q.data;

endmodule

// File: tb/tb_exmem_memwb_pipe.sv
// Directed bench for exmem_memwb_pipe: ALU forwarding, x0 filtering, waited load,
// zero-wait store, reset during a wait and a load followed by a stalled ALU op.
module tb_exmem_memwb_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [4:0]  ex_rd;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall;
  logic [4:0]  exmem_rd;
  logic        exmem_regwrite;
  logic [31:0] exmem_result;
  logic [4:0]  memwb_rd;
  logic        memwb_regwrite;
  logic [31:0] memwb_data;

  int checks = 0;
  int errors = 0;

  exmem_memwb_pipe dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
    .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall),
    .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .exmem_result(exmem_result),
    .memwb_rd(memwb_rd), .memwb_regwrite(memwb_regwrite), .memwb_data(memwb_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic mw,
                          input logic [31:0] res, input logic [31:0] sd);
    ex_valid = v; ex_rd = rd; ex_regwrite = rw; ex_memread = mr;
    ex_memwrite = mw; ex_alu_result = res; ex_store_data = sd;
  endtask

  task automatic drive_idle();
    drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    logic [31:0] all_out;
    reset = 1'b1; dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive_idle();
    tick(); tick();
    all_out = {31'd0, dmem_req} | {31'd0, dmem_we} | dmem_addr | dmem_wdata |
              {31'd0, stall} | {27'd0, exmem_rd} | {31'd0, exmem_regwrite} |
              exmem_result | {27'd0, memwb_rd} | {31'd0, memwb_regwrite} | memwb_data;
    checks++;
    if (all_out !== 32'h0) begin
      errors++; $display("FAIL reset_outputs: got or-reduce %h, expected 00000000", all_out);
    end
    checks++;
    if (stall !== 1'b0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL reset_req_stall: got req=%b stall=%b, expected 0 0", dmem_req, stall);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_alu_op();
    @(negedge clk);
    drive_ex(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 32'h1234, 32'h0);
    tick();
    checks++;
    if (exmem_rd !== 5'd5 || exmem_regwrite !== 1'b1 || exmem_result !== 32'h1234) begin
      errors++; $display("FAIL alu_exmem: got rd=%0d rw=%b res=%h, expected 5 1 00001234",
                         exmem_rd, exmem_regwrite, exmem_result);
    end
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL alu_no_req: got req=%b stall=%b, expected 0 0", dmem_req, stall);
    end
    drive_idle();
    tick();
    checks++;
    if (memwb_rd !== 5'd5 || memwb_regwrite !== 1'b1 || memwb_data !== 32'h1234) begin
      errors++; $display("FAIL alu_memwb: got rd=%0d rw=%b data=%h, expected 5 1 00001234",
                         memwb_rd, memwb_regwrite, memwb_data);
    end
    checks++;
    if (exmem_regwrite !== 1'b0) begin
      errors++; $display("FAIL alu_bubble: got exmem_regwrite=%b, expected 0", exmem_regwrite);
    end
  endtask

  task automatic test_x0_filter();
    @(negedge clk);
    drive_ex(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 32'h55, 32'h0);
    tick();
    checks++;
    if (exmem_regwrite !== 1'b0) begin
      errors++; $display("FAIL x0_exmem: got exmem_regwrite=%b, expected 0", exmem_regwrite);
    end
    drive_idle();
    tick();
    checks++;
    if (memwb_regwrite !== 1'b0) begin
      errors++; $display("FAIL x0_memwb: got memwb_regwrite=%b, expected 0", memwb_regwrite);
    end
  endtask

  task automatic test_invalid_memop();
    @(negedge clk);
    drive_ex(1'b0, 5'd4, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0);
    tick();
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || exmem_regwrite !== 1'b0) begin
      errors++; $display("FAIL invalid_memop: got req=%b stall=%b rw=%b, expected 0 0 0",
                         dmem_req, stall, exmem_regwrite);
    end
    drive_idle();
  endtask

  task automatic test_load_wait();
    int stall_cycles = 0;
    int bad_hold = 0;
    @(negedge clk);
    drive_ex(1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 32'h100, 32'h0);
    tick();
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc == 3) begin
        dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
      end
      #1;
      if (stall === 1'b1) stall_cycles++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h100 ||
          exmem_rd !== 5'd7 || exmem_regwrite !== 1'b1) bad_hold++;
      if (cyc > 0 && memwb_regwrite !== 1'b0) bad_hold++;
      if (cyc < 3) tick();
    end
    checks++;
    if (stall_cycles != 3) begin
      errors++; $display("FAIL load_stall_len: got %0d cycles, expected 3", stall_cycles);
    end
    checks++;
    if (bad_hold != 0) begin
      errors++; $display("FAIL load_hold: got %0d bad samples, expected 0", bad_hold);
    end
    drive_idle();
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    #1;
    checks++;
    if (memwb_rd !== 5'd7 || memwb_regwrite !== 1'b1 || memwb_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_wb: got rd=%0d rw=%b data=%h, expected 7 1 deadbeef",
                         memwb_rd, memwb_regwrite, memwb_data);
    end
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL load_release: got req=%b stall=%b, expected 0 0", dmem_req, stall);
    end
  endtask

  task automatic test_store_zero_wait();
    @(negedge clk);
    drive_ex(1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 32'h200, 32'hCAFEF00D);
    tick();
    dmem_ack = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h200 ||
        dmem_wdata !== 32'hCAFEF00D || stall !== 1'b0) begin
      errors++; $display("FAIL store_req: got req=%b we=%b addr=%h wdata=%h stall=%b, expected 1 1 00000200 cafef00d 0",
                         dmem_req, dmem_we, dmem_addr, dmem_wdata, stall);
    end
    drive_idle();
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (dmem_we !== 1'b0 || dmem_req !== 1'b0 || memwb_regwrite !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL store_done: got we=%b req=%b memwb_rw=%b stall=%b, expected 0 0 0 0",
                         dmem_we, dmem_req, memwb_regwrite, stall);
    end
  endtask

  task automatic test_reset_in_wait();
    @(negedge clk);
    drive_ex(1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 32'h300, 32'h0);
    tick();
    tick();
    checks++;
    if (stall !== 1'b1 || dmem_req !== 1'b1) begin
      errors++; $display("FAIL rst_wait_entry: got stall=%b req=%b, expected 1 1", stall, dmem_req);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall !== 1'b0 || exmem_rd !== 5'd0 || exmem_regwrite !== 1'b0 ||
        exmem_result !== 32'h0 || memwb_rd !== 5'd0 || memwb_regwrite !== 1'b0 ||
        memwb_data !== 32'h0 || dmem_addr !== 32'h0) begin
      errors++; $display("FAIL rst_wait_clear: got req=%b stall=%b exmem=%0d/%b/%h memwb=%0d/%b/%h, expected all 0",
                         dmem_req, stall, exmem_rd, exmem_regwrite, exmem_result,
                         memwb_rd, memwb_regwrite, memwb_data);
    end
    drive_idle();
    @(negedge clk);
    reset = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'h77;
    tick();
    dmem_ack = 1'b0;
    #1;
    checks++;
    if (memwb_regwrite !== 1'b0 || memwb_data !== 32'h0 || dmem_req !== 1'b0) begin
      errors++; $display("FAIL rst_late_ack: got rw=%b data=%h req=%b, expected 0 00000000 0",
                         memwb_regwrite, memwb_data, dmem_req);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive_ex(1'b1, 5'd8, 1'b1, 1'b1, 1'b0, 32'h400, 32'h0);
    tick();
    // ALU op now waits in EX, held stable while stall is high
    drive_ex(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 32'hA5A5, 32'h0);
    tick();
    checks++;
    if (stall !== 1'b1 || exmem_rd !== 5'd8 || memwb_regwrite !== 1'b0) begin
      errors++; $display("FAIL b2b_hold: got stall=%b exmem_rd=%0d memwb_rw=%b, expected 1 8 0",
                         stall, exmem_rd, memwb_regwrite);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    tick();
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    drive_idle();
    #1;
    checks++;
    if (memwb_rd !== 5'd8 || memwb_regwrite !== 1'b1 || memwb_data !== 32'h0BADF00D ||
        exmem_rd !== 5'd9 || exmem_regwrite !== 1'b1 || stall !== 1'b0) begin
      errors++; $display("FAIL b2b_load_wb: got memwb=%0d/%b/%h exmem=%0d/%b stall=%b, expected 8/1/0badf00d 9/1 0",
                         memwb_rd, memwb_regwrite, memwb_data, exmem_rd, exmem_regwrite, stall);
    end
    tick();
    checks++;
    if (memwb_rd !== 5'd9 || memwb_regwrite !== 1'b1 || memwb_data !== 32'hA5A5) begin
      errors++; $display("FAIL b2b_alu_wb: got rd=%0d rw=%b data=%h, expected 9 1 0000a5a5",
                         memwb_rd, memwb_regwrite, memwb_data);
    end
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_x0_filter();
    test_invalid_memop();
    test_load_wait();
    test_store_zero_wait();
    test_reset_in_wait();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exmem_memwb_pipe.md
# exmem_memwb_pipe

Back-end pipeline register block holding the EX/MEM and MEM/WB stages of the 5-stage RV32 core. It produces every destination tag, write-enable and result value that the forwarding logic consumes (`exmem_*`, `memwb_*`) and drives register-file writeback. It also runs the data-memory request/acknowledge handshake, stalling the front end while a load or store is outstanding.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `RA_W`, 5, register address width.

Ports:
- `clk` in 1, single clock, rising edge.
- `reset` in 1, asynchronous, active-high.
- `ex_valid` in 1, EX stage holds a real instruction.
- `ex_rd` in RA_W, destination register.
- `ex_regwrite` in 1, instruction writes `rd`.
- `ex_memread` in 1, load.
- `ex_memwrite` in 1, store.
- `ex_alu_result` in XLEN, ALU result; also the memory address.
- `ex_store_data` in XLEN, store data, already forwarded.
- `dmem_req` out 1, memory request.
- `dmem_we` out 1, 1 = write.
- `dmem_addr` out XLEN, memory address.
- `dmem_wdata` out XLEN, write data.
- `dmem_rdata` in XLEN, read data, valid when `dmem_ack` is high.
- `dmem_ack` in 1, request complete; may assert in the same cycle as `dmem_req`.
- `stall` out 1, freezes PC, IF/ID and ID/EX; EX inputs are held stable while it is high.
- `exmem_rd` out RA_W, forwarding tag.
- `exmem_regwrite` out 1, forwarding tag valid.
- `exmem_result` out XLEN, forwarding value.
- `memwb_rd` out RA_W, writeback/forwarding tag.
- `memwb_regwrite` out 1, register-file write enable.
- `memwb_data` out XLEN, writeback/forwarding value.

## Operation
- EX/MEM register: captures `ex_*` on every rising edge where `stall` = 0.
  - Captured regwrite = `ex_valid & ex_regwrite & (ex_rd != 0)`. The x0 filter is applied here so both output tags never assert for x0.
  - Captured memread and memwrite are likewise gated by `ex_valid`.
- FSM, states `IDLE` and `WAIT`:
  - `IDLE`: if EX/MEM holds a memory op, drive `dmem_req` = 1 combinationally.
    - If `dmem_ack` is also high, the op completes this cycle and the state stays `IDLE`.
    - Otherwise go to `WAIT`.
  - `WAIT`: keep `dmem_req`, `dmem_we`, `dmem_addr` and `dmem_wdata` stable from EX/MEM. Return to `IDLE` on `dmem_ack`.
- `stall` = memory op in EX/MEM & ~`dmem_ack`. It is combinational so that a zero-wait memory costs no cycles.
- MEM/WB register, updated every edge:
  - Memory op pending (`stall` = 1): capture a bubble (regwrite = 0; rd and data hold their old values).
  - Load with ack: data = `dmem_rdata`, rd and regwrite from EX/MEM.
  - Store with ack: regwrite = 0.
  - Non-memory op: data = EX/MEM result, rd and regwrite from EX/MEM.
- While `stall` = 1, EX/MEM holds its contents, so its forwarding tags stay valid throughout the wait.
- A load's `exmem_result` is the address, not the data. Load-use interlock is the hazard unit's job, not this block's.
- Asserting `reset` mid-handshake:
  - FSM returns to `IDLE`.
  - `dmem_req` drops immediately.
  - Both stages are emptied.
  - A late `dmem_ack` after reset is ignored.

## Timing
- Reset values: all registered state is 0, so every output listed here reads 0 in reset:
  - `exmem_rd`, `exmem_regwrite`, `exmem_result`.
  - `memwb_rd`, `memwb_regwrite`, `memwb_data`.
  - `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `stall`.
  - FSM state = `IDLE`.
- ALU op: EX inputs at edge N → `exmem_*` valid after edge N → `memwb_*` valid after edge N+1.
- Load with ack in cycle k: `memwb_data` = `dmem_rdata` after edge k. `stall` is high for (wait cycles) cycles, 0 for a zero-wait ack.
- `ex_valid` = 0 with a memory-op flag set: no request is issued.
- Consecutive memory ops: each op gets its own request. A new request is issued in the cycle after the previous ack.

## Structure
- Shared package `core_pkg`: `XLEN`, `RA_W`, FSM state enum (`IDLE`, `WAIT`), EX/MEM and MEM/WB struct typedefs.
- One sub-module, `dmem_handshake_fsm`: owns the state register and produces `dmem_req` and `stall` from the pending-op flag and `dmem_ack`.

## Test plan
- ALU op: `ex_rd`=5, regwrite=1, result=0x1234 → `exmem_rd`=5 / `exmem_regwrite`=1 next cycle; `memwb_regwrite`=1, `memwb_data`=0x1234 one cycle later.
- `ex_rd`=0 with regwrite=1 → `exmem_regwrite` and `memwb_regwrite` stay 0.
- Load to x7, address 0x100, ack delayed 3 cycles with rdata=0xDEADBEEF:
  - `stall` high exactly 3 cycles; `dmem_addr`=0x100 held stable.
  - MEM/WB shows bubbles during the wait, then `memwb_rd`=7, data=0xDEADBEEF.
- Store with same-cycle ack: `dmem_we`=1 for one cycle, `stall` never high, `memwb_regwrite`=0.
- `reset` pulsed while in `WAIT`: `dmem_req` falls in that cycle; all outputs read 0; a later ack produces no writeback.
- Back-to-back load then ALU op: ALU op held in EX until the load's ack, then it retires one cycle after the load.
